// File: rtl/ram_arbiter.sv
// Round-robin arbiter and command sequencer that shares one single-port SPI RAM between two requesters.
// Optional build macro RAM_ARB_TIMEOUT_EN adds an RD_WAIT timeout and an err flag reported with done.
module ram_arbiter #(
  parameter int WIDTH = 8
`ifdef RAM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH+1:0] ram_din,
  output logic             ram_rx_valid,
  input  logic             ram_tx_valid,
  input  logic [WIDTH-1:0] ram_dout
`ifdef RAM_ARB_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_CMD  = 3'd4,
    RD_WAIT = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [WIDTH+1:0] din_q, din_d;
  logic             rxv_q, rxv_d;
  logic             grant, win, rd_hit;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timed_out;
`endif

  // State and output registers; operand latches carry no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      din_q      <= '0;
      rxv_q      <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      din_q      <= din_d;
      rxv_q      <= rxv_d;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Next-state: last_gnt only moves when both requesters contend
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    win        = owner_q;
    last_gnt_d = last_gnt_q;
    rd_hit     = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
    timed_out  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant = 1'b1;
          if (req0 && req1) begin
            win        = ~last_gnt_q;
            last_gnt_d = ~last_gnt_q;
          end else begin
            win = req1;
          end
          state_d = (win ? we1 : we0) ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: state_d = WR_DATA;
      WR_DATA: state_d = DONE;
      RD_ADDR: state_d = RD_CMD;
      RD_CMD:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (ram_tx_valid) begin
          rd_hit  = 1'b1;
          state_d = DONE;
        end
`ifdef RAM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          timed_out = 1'b1;
          state_d   = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they line up with it once registered
  always_comb begin
    owner_d = grant ? win : owner_q;
    addr_d  = grant ? (win ? addr1 : addr0) : addr_q;
    wdata_d = grant ? (win ? wdata1 : wdata0) : wdata_q;
    gnt0_d  = (state_d != IDLE) && !owner_d;
    gnt1_d  = (state_d != IDLE) && owner_d;
    done0_d = (state_d == DONE) && !owner_d;
    done1_d = (state_d == DONE) && owner_d;
    rxv_d   = 1'b0;
    din_d   = din_q;
    case (state_d)
      WR_ADDR: begin
        rxv_d = 1'b1;
        din_d = {2'b00, addr_d};
      end
      WR_DATA: begin
        rxv_d = 1'b1;
        din_d = {2'b01, wdata_d};
      end
      RD_ADDR: begin
        rxv_d = 1'b1;
        din_d = {2'b10, addr_d};
      end
      RD_CMD: begin
        rxv_d = 1'b1;
        din_d = {2'b11, {WIDTH{1'b0}}};
      end
      default: ;
    endcase
    rdata0_d = (rd_hit && !owner_q) ? ram_dout : rdata0_q;
    rdata1_d = (rd_hit && owner_q) ? ram_dout : rdata1_q;
`ifdef RAM_ARB_TIMEOUT_EN
    err_d = timed_out;
    cnt_d = (state_q == RD_WAIT) ? cnt_q + 1'b1 : '0;
`endif
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign ram_din      = din_q;
  assign ram_rx_valid = rxv_q;
`ifdef RAM_ARB_TIMEOUT_EN
  assign err          = err_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: random two-requester traffic against a behavioural RAM and memory model.
// Timeout checks are included when RAM_ARB_TIMEOUT_EN is defined.
module tb_ram_arbiter;

  localparam int TMO = 4;
`ifdef RAM_ARB_TIMEOUT_EN
  localparam int MAXD = TMO - 1;
`else
  localparam int MAXD = 6;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] rdata0, rdata1;
  logic [9:0] ram_din;
  logic       ram_rx_valid, ram_tx_valid;
  logic [7:0] ram_dout;
`ifdef RAM_ARB_TIMEOUT_EN
  logic       err;
`endif

  logic [7:0] ref_mem [256];
  logic [7:0] ram_mem [256];
  logic [7:0] ref_rdata [2];
  exp_t       exp0[$];
  exp_t       exp1[$];
  int         glog[$];
  int         errors = 0;
  int         checks = 0;
  bit         ram_mute = 1'b0;
  bit         stray_pend = 1'b0;
  int         fixed_delay = -1;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout)
`ifdef RAM_ARB_TIMEOUT_EN
    , .err(err)
`endif
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic drive(input bit who, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    if (who) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic scramble(input bit who);
    if (who) begin
      addr1 = 8'($urandom); wdata1 = 8'($urandom);
    end else begin
      addr0 = 8'($urandom); wdata0 = 8'($urandom);
    end
  endtask

  // Reference: a write updates memory, a read returns memory, a timeout leaves rdata untouched
  task automatic push_exp(input bit who, input bit rd, input logic [7:0] a,
                          input logic [7:0] d, input bit tmo);
    exp_t e;
    if (!rd) ref_mem[a] = d;
    else if (!tmo) ref_rdata[who] = ref_mem[a];
    e.data = ref_rdata[who];
    e.err  = tmo;
    if (who) exp1.push_back(e);
    else     exp0.push_back(e);
  endtask

  initial begin : ram_model
    bit         pend;
    int         cnt;
    logic [7:0] wa, ra, rd;
    pend = 1'b0; cnt = 0; wa = '0; ra = '0; rd = '0;
    ram_tx_valid = 1'b0;
    ram_dout = '0;
    for (int i = 0; i < 256; i++) ram_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      ram_tx_valid = 1'b0;
      if (rst) pend = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          ram_tx_valid = 1'b1;
          ram_dout = rd;
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (stray_pend) begin
        ram_tx_valid = 1'b1;
        ram_dout = 8'hFF;
        stray_pend = 1'b0;
      end
      if (ram_rx_valid && !rst) begin
        case (ram_din[9:8])
          2'b00: wa = ram_din[7:0];
          2'b01: ram_mem[wa] = ram_din[7:0];
          2'b10: ra = ram_din[7:0];
          default: begin
            pend = !ram_mute;
            rd = ram_mem[ra];
            cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, MAXD));
          end
        endcase
      end
    end
  end

  initial begin : monitor
    bit   pg0, pg1;
    exp_t e;
    pg0 = 1'b0; pg1 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pg0 = 1'b0; pg1 = 1'b0;
      end else begin
        if (gnt0 || gnt1) chk("gnt_exclusive", 32'(gnt0 & gnt1), 0);
        if (gnt0 && !pg0) glog.push_back(0);
        if (gnt1 && !pg1) glog.push_back(1);
        pg0 = gnt0; pg1 = gnt1;
        if (done0) begin
          chk("done0_with_gnt0", 32'(gnt0), 1);
          chk("done0_expected", 32'(exp0.size() > 0), 1);
          if (exp0.size() > 0) begin
            e = exp0.pop_front();
            chk("rdata0_at_done", 32'(rdata0), 32'(e.data));
`ifdef RAM_ARB_TIMEOUT_EN
            chk("err_at_done0", 32'(err), 32'(e.err));
`endif
          end
        end
        if (done1) begin
          chk("done1_with_gnt1", 32'(gnt1), 1);
          chk("done1_expected", 32'(exp1.size() > 0), 1);
          if (exp1.size() > 0) begin
            e = exp1.pop_front();
            chk("rdata1_at_done", 32'(rdata1), 32'(e.data));
`ifdef RAM_ARB_TIMEOUT_EN
            chk("err_at_done1", 32'(err), 32'(e.err));
`endif
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    exp0.delete(); exp1.delete();
    ref_rdata[0] = '0; ref_rdata[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wr_directed(input bit who, input logic [7:0] a, input logic [7:0] d, input bit stray);
    @(posedge clk); #1;
    drive(who, 1, 1, a, d);
    push_exp(who, 0, a, d, 0);
    @(negedge clk);
    @(negedge clk);
    chk("wr_t1_din", 32'(ram_din), 32'({2'b00, a}));
    chk("wr_t1_rxv", 32'(ram_rx_valid), 1);
    chk("wr_t1_gnt", 32'(who ? gnt1 : gnt0), 1);
    @(posedge clk); #1;
    if (stray) stray_pend = 1'b1;
    @(negedge clk);
    chk("wr_t2_din", 32'(ram_din), 32'({2'b01, d}));
    chk("wr_t2_rxv", 32'(ram_rx_valid), 1);
    @(negedge clk);
    chk("wr_t3_done", 32'(who ? done1 : done0), 1);
    chk("wr_t3_rxv", 32'(ram_rx_valid), 0);
    @(posedge clk); #1;
    drive(who, 0, 0, 8'($urandom), 8'($urandom));
    @(negedge clk);
    chk("wr_t4_gnt_drop", 32'({gnt0, gnt1, done0, done1}), 0);
    chk("wr_t4_din_held", 32'(ram_din), 32'({2'b01, d}));
  endtask

  task automatic rd_directed(input bit who, input logic [7:0] a, input int delay, input bit tmo);
    int k;
    bit got;
    @(posedge clk); #1;
    fixed_delay = delay;
    ram_mute = tmo;
    drive(who, 1, 0, a, 8'($urandom));
    push_exp(who, 1, a, 0, tmo);
    @(negedge clk);
    @(negedge clk);
    chk("rd_t1_din", 32'(ram_din), 32'({2'b10, a}));
    @(negedge clk);
    chk("rd_t2_din", 32'(ram_din), 32'h300);
    chk("rd_t2_rxv", 32'(ram_rx_valid), 1);
    k = 2;
    got = 1'b0;
    while (!got && k < 60) begin
      @(negedge clk);
      k++;
      if (who ? done1 : done0) got = 1'b1;
    end
    chk("rd_done_latency", 32'(k), 32'(tmo ? 3 + TMO : delay + 4));
    @(posedge clk); #1;
    drive(who, 0, 0, 8'($urandom), 8'($urandom));
    fixed_delay = -1;
    ram_mute = 1'b0;
  endtask

  task automatic do_txn(input bit who, input bit w, input logic [7:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    drive(who, 1, w, a, d);
    push_exp(who, !w, a, d, 0);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (who ? done1 : done0) got = 1'b1;
      else if (who ? gnt1 : gnt0) scramble(who);
    end
    chk(who ? "txn1_completed" : "txn0_completed", 32'(got), 1);
    @(posedge clk); #1;
    drive(who, 0, w, 8'($urandom), 8'($urandom));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'({gnt0, gnt1}), 0);
    chk("rst_done", 32'({done0, done1}), 0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 0);
    chk("rst_din", 32'(ram_din), 0);
    chk("rst_rxv", 32'(ram_rx_valid), 0);

    wr_directed(0, 8'h3C, 8'hA5, 0);
    rd_directed(1, 8'h3C, 2, 0);
    chk("rd_rdata1", 32'(rdata1), 32'h A5);

    // Stray tx_valid while idle, then during the write data phase
    @(posedge clk); #1;
    stray_pend = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_idle_done", 32'({done0, done1}), 0);
    end
    chk("stray_idle_rdata0", 32'(rdata0), 0);
    chk("stray_idle_rdata1", 32'(rdata1), 32'hA5);
    wr_directed(0, 8'h44, 8'h5A, 1);
    chk("stray_wr_rdata0", 32'(rdata0), 0);
    chk("stray_wr_rdata1", 32'(rdata1), 32'hA5);

    // Contention from reset: both requesters hold req for two transactions each
    do_reset();
    glog.delete();
    fork
      begin
        do_txn(0, 1, 8'h50, 8'h11);
        do_txn(0, 0, 8'h50, 8'h00);
      end
      begin
        do_txn(1, 1, 8'h51, 8'h22);
        do_txn(1, 0, 8'h3C, 8'h00);
      end
    join
    chk("contention_grants", 32'(glog.size()), 4);
    if (glog.size() >= 4) begin
      chk("contention_order0", 32'(glog[0]), 0);
      chk("contention_order1", 32'(glog[1]), 1);
      chk("contention_order2", 32'(glog[2]), 0);
      chk("contention_order3", 32'(glog[3]), 1);
    end

    // Reset while parked in RD_WAIT
    @(posedge clk); #1;
    ram_mute = 1'b1;
    drive(0, 1, 0, 8'h20, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rdwait_gnt0", 32'(gnt0), 1);
    chk("rdwait_rxv", 32'(ram_rx_valid), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    ram_mute = 1'b0;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    @(negedge clk);
    chk("midrst_outs", 32'({gnt0, gnt1, done0, done1, ram_rx_valid}), 0);
    chk("midrst_rdata", 32'({rdata0, rdata1}), 0);
    chk("midrst_din", 32'(ram_din), 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", 32'({done0, done1}), 0);
    end
    wr_directed(1, 8'h21, 8'h99, 0);

    // Random traffic: requester 0 owns even addresses, requester 1 odd ones
    fork
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_txn(0, 1'($urandom_range(0, 1)), {7'($urandom), 1'b0}, 8'($urandom));
      end
      for (int j = 0; j < 20; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_txn(1, 1'($urandom_range(0, 1)), {7'($urandom), 1'b1}, 8'($urandom));
      end
    join

`ifdef RAM_ARB_TIMEOUT_EN
    wr_directed(0, 8'h10, 8'hA5, 0);
    rd_directed(0, 8'h10, 1, 0);
    chk("tmo_pre_rdata0", 32'(rdata0), 32'hA5);
    rd_directed(0, 8'h12, 0, 1);
    chk("tmo_rdata0_kept", 32'(rdata0), 32'hA5);
    @(negedge clk);
    chk("tmo_err_cleared", 32'(err), 0);
`endif

    repeat (5) @(negedge clk);
    chk("exp0_drained", 32'(exp0.size()), 0);
    chk("exp1_drained", 32'(exp1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
